// File: rtl/tv80_alu16_seq.sv
// Sequences a 16-bit ADD/ADC/SBC through an external 8-bit TV80 ALU as a
// low-byte pass followed by a high-byte pass.
module tv80_alu16_seq #(
    parameter int Flag_C = 0,
    parameter int Flag_N = 1,
    parameter int Flag_P = 2,
    parameter int Flag_X = 3,
    parameter int Flag_H = 4,
    parameter int Flag_Y = 5,
    parameter int Flag_Z = 6,
    parameter int Flag_S = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic [7:0]  f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  f_out,
    output logic [3:0]  alu_op,
    output logic        alu_arith16,
    output logic        alu_z16,
    output logic [7:0]  alu_busa,
    output logic [7:0]  alu_busb,
    output logic [7:0]  alu_f_in,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_f_out
);

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    state_t      state;
    logic [15:0] opa_r;
    logic [15:0] opb_r;
    logic [1:0]  op_r;
    logic [7:0]  f_r;
    logic [7:0]  lo_q;
    logic        lo_c;
    logic        lo_z;
    logic        is_add;
    logic        is_sbc;

    assign is_add = (op_r == 2'b00);
    assign is_sbc = (op_r == 2'b10);

    always_comb begin
        alu_op      = 4'b0000;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;
        alu_busa    = '0;
        alu_busb    = '0;
        alu_f_in    = f_in;
        case (state)
            LO: begin
                alu_busa    = opa_r[7:0];
                alu_busb    = opb_r[7:0];
                alu_op      = is_sbc ? 4'b0011 : (is_add ? 4'b0000 : 4'b0001);
                alu_f_in    = f_r;
                alu_arith16 = is_add;
            end
            HI: begin
                alu_busa    = opa_r[15:8];
                alu_busb    = opb_r[15:8];
                alu_op      = is_sbc ? 4'b0011 : 4'b0001;
                alu_f_in    = f_r;
                // High byte chains the low-byte carry; ADC/SBC also chain the
                // low-byte zero so the ALU's Z16 mode yields a 16-bit Z.
                alu_f_in[Flag_C] = lo_c;
                if (!is_add) alu_f_in[Flag_Z] = lo_z;
                alu_arith16 = is_add;
                alu_z16     = !is_add;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            f_out  <= '0;
            opa_r  <= '0;
            opb_r  <= '0;
            op_r   <= '0;
            f_r    <= '0;
            lo_q   <= '0;
            lo_c   <= 1'b0;
            lo_z   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (op != 2'b11)) begin
                        opa_r <= opa;
                        opb_r <= opb;
                        op_r  <= op;
                        f_r   <= f_in;
                        busy  <= 1'b1;
                        state <= LO;
                    end
                end
                LO: begin
                    // Low byte is parked so result only changes at the HI capture.
                    lo_q  <= alu_q;
                    lo_c  <= alu_f_out[Flag_C];
                    lo_z  <= (alu_q == 8'h00);
                    state <= HI;
                end
                HI: begin
                    result <= {alu_q, lo_q};
                    f_out  <= alu_f_out;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Bench for tv80_alu16_seq: emulates the 8-bit TV80 ALU and checks 16-bit
// results against an arithmetic reference model.
module tb_tv80_alu16_seq;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [15:0] opa, opb;
    logic [7:0]  f_in;
    logic        busy, done;
    logic [15:0] result;
    logic [7:0]  f_out;
    logic [3:0]  alu_op;
    logic        alu_arith16, alu_z16;
    logic [7:0]  alu_busa, alu_busb, alu_f_in;
    logic [7:0]  alu_q, alu_f_out;

    int n_assert = 0;
    int n_fail   = 0;

    tv80_alu16_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .f_in(f_in), .busy(busy), .done(done), .result(result), .f_out(f_out),
        .alu_op(alu_op), .alu_arith16(alu_arith16), .alu_z16(alu_z16),
        .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_f_in(alu_f_in),
        .alu_q(alu_q), .alu_f_out(alu_f_out)
    );

    always #5 clk = ~clk;

    // 8-bit TV80 ALU behaviour for ADD/ADC/SUB/SBC, returns {Q, F_Out}
    function automatic logic [15:0] alu8(input logic [3:0] aop, input logic [7:0] a, b, fi,
                                         input logic ar16, z16);
        logic       sub, cin, ov;
        logic [8:0] full;
        logic [4:0] half;
        logic [7:0] q, fo;
        sub = (aop == 4'd2) || (aop == 4'd3);
        cin = aop[0] & fi[0];
        if (sub) begin
            full = {1'b0, a} - {1'b0, b} - {8'b0, cin};
            half = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, cin};
            ov   = (a[7] != b[7]) && (full[7] != a[7]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {8'b0, cin};
            half = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
            ov   = (a[7] == b[7]) && (full[7] != a[7]);
        end
        q = full[7:0];
        fo = '0;
        fo[0] = full[8];
        fo[1] = sub;
        fo[2] = ov;
        fo[3] = q[3];
        fo[4] = half[4];
        fo[5] = q[5];
        fo[6] = (q == 8'h00) ? (z16 ? fi[6] : 1'b1) : 1'b0;
        fo[7] = q[7];
        if (ar16) begin
            fo[7] = fi[7];
            fo[6] = fi[6];
            fo[2] = fi[2];
        end
        return {q, fo};
    endfunction

    always_comb {alu_q, alu_f_out} = alu8(alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16);

    // 16-bit reference in plain integer arithmetic, returns {result, flags}
    function automatic logic [23:0] ref16(input logic [1:0] o, input logic [15:0] a, b,
                                          input logic [7:0] fi);
        int unsigned ai, bi, cin, r;
        int          sa, sb, sr;
        logic        sub, c, h, ov;
        logic [15:0] res;
        logic [7:0]  f;
        sub = (o == 2'd2);
        cin = (o == 2'd0) ? 0 : int'(fi[0]);
        ai = a; bi = b;
        sa = a[15] ? int'(ai) - 65536 : int'(ai);
        sb = b[15] ? int'(bi) - 65536 : int'(bi);
        if (sub) begin
            r  = ai - bi - cin;
            c  = ai < bi + cin;
            h  = (ai & 32'hFFF) < (bi & 32'hFFF) + cin;
            sr = sa - sb - int'(cin);
        end else begin
            r  = ai + bi + cin;
            c  = r > 32'hFFFF;
            h  = (ai & 32'hFFF) + (bi & 32'hFFF) + cin > 32'hFFF;
            sr = sa + sb + int'(cin);
        end
        ov  = (sr > 32767) || (sr < -32768);
        res = r[15:0];
        if (o == 2'd0) f = {fi[7], fi[6], res[13], h, res[11], fi[2], 1'b0, c};
        else           f = {res[15], res == 16'h0000, res[13], h, res[11], ov, sub, c};
        return {res, f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full operation with per-phase checks; inputs are scrambled after acceptance
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, b, input logic [7:0] fi);
        logic [23:0] e;
        logic [15:0] prev_res;
        logic [7:0]  hf;
        int unsigned la, lb, cin, lsum;
        e = ref16(o, a, b, fi);
        prev_res = result;
        la = a[7:0]; lb = b[7:0];
        cin = (o == 2'd0) ? 0 : int'(fi[0]);
        lsum = (o == 2'd2) ? la - lb - cin : la + lb + cin;
        hf = fi;
        hf[0] = (o == 2'd2) ? (la < lb + cin) : (lsum > 255);
        if (o != 2'd0) hf[6] = (lsum[7:0] == 8'h00);
        op = o; opa = a; opb = b; f_in = fi; start = 1'b1;
        tick();
        start = 1'b0; op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom); f_in = 8'($urandom);
        chk("lo_busy", busy, 1);
        chk("lo_busa", alu_busa, a[7:0]);
        chk("lo_busb", alu_busb, b[7:0]);
        chk("lo_op", alu_op, (o == 2'd2) ? 3 : ((o == 2'd1) ? 1 : 0));
        chk("lo_fin", alu_f_in, fi);
        chk("lo_ar16", alu_arith16, o == 2'd0);
        chk("lo_z16", alu_z16, 0);
        chk("lo_hold", result, prev_res);
        tick();
        chk("hi_busy", busy, 1);
        chk("hi_busa", alu_busa, a[15:8]);
        chk("hi_busb", alu_busb, b[15:8]);
        chk("hi_op", alu_op, (o == 2'd2) ? 3 : 1);
        chk("hi_fin", alu_f_in, hf);
        chk("hi_z16", alu_z16, o != 2'd0);
        chk("hi_hold", result, prev_res);
        tick();
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("result", result, e[23:8]);
        chk("f_out", f_out, e[7:0]);
        tick();
        chk("done_pulse", done, 0);
        chk("res_hold", result, e[23:8]);
    endtask

    initial begin
        logic [15:0] ra, rb, keep_r;
        logic [7:0]  keep_f;
        logic [23:0] ea, eb;

        reset = 1'b1; start = 1'b0; op = 2'd0; opa = '0; opb = '0; f_in = 8'h5A;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 16'h0000);
        chk("rst_f_out", f_out, 8'h00);
        chk("idle_op", alu_op, 0);
        chk("idle_busa", alu_busa, 0);
        chk("idle_busb", alu_busb, 0);
        chk("idle_fin", alu_f_in, 8'h5A);
        chk("idle_ar16", alu_arith16, 0);
        chk("idle_z16", alu_z16, 0);
        reset = 1'b0;
        tick();

        run_op(2'd0, 16'h0FFF, 16'h0001, 8'hFF);
        chk("vec_add_r", result, 16'h1000);
        chk("vec_add_f", f_out, 8'hD4);
        run_op(2'd1, 16'hFFFF, 16'h0000, 8'h01);
        chk("vec_adc_r", result, 16'h0000);
        chk("vec_adc_f", f_out, 8'h51);
        run_op(2'd2, 16'h8000, 16'h0001, 8'h00);
        chk("vec_sbc1_r", result, 16'h7FFF);
        chk("vec_sbc1_f", f_out, 8'h3E);
        run_op(2'd2, 16'h1234, 16'h1234, 8'h00);
        chk("vec_sbc2_r", result, 16'h0000);
        chk("vec_sbc2_f", f_out, 8'h42);
        run_op(2'd2, 16'h0100, 16'h0000, 8'h00);
        chk("vec_sbc3_r", result, 16'h0100);
        chk("vec_sbc3_z", f_out[6], 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: ra = 16'h0000;
                1: ra = 16'hFFFF;
                2: ra = 16'h8000;
                default: ra = 16'($urandom);
            endcase
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            run_op(2'($urandom_range(0, 2)), ra, rb, 8'($urandom));
        end

        // start held through LO and HI is ignored; op=11 in IDLE is ignored
        ea = ref16(2'd1, 16'h4321, 16'h1111, 8'h01);
        op = 2'd1; opa = 16'h4321; opb = 16'h1111; f_in = 8'h01; start = 1'b1;
        tick();
        op = 2'd2; opa = 16'hAAAA; opb = 16'h5555; f_in = 8'hFF;
        tick();
        tick();
        start = 1'b0;
        chk("ign_done", done, 1);
        chk("ign_result", result, ea[23:8]);
        chk("ign_f_out", f_out, ea[7:0]);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ign_no_done", done, 0);
            chk("ign_no_busy", busy, 0);
        end
        op = 2'd3; start = 1'b1;
        tick();
        chk("op3_busy", busy, 0);
        tick();
        start = 1'b0;
        chk("op3_done", done, 0);
        chk("op3_result", result, ea[23:8]);
        chk("op3_f_out", f_out, ea[7:0]);

        // back-to-back: new start in the done cycle
        ea = ref16(2'd0, 16'h7FF0, 16'h0020, 8'hC5);
        eb = ref16(2'd2, 16'h0001, 16'h0002, 8'h01);
        op = 2'd0; opa = 16'h7FF0; opb = 16'h0020; f_in = 8'hC5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("b2b_done1", done, 1);
        chk("b2b_res1", result, ea[23:8]);
        op = 2'd2; opa = 16'h0001; opb = 16'h0002; f_in = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_hold_lo", result, ea[23:8]);
        chk("b2b_no_done", done, 0);
        tick();
        chk("b2b_hold_hi", f_out, ea[7:0]);
        tick();
        chk("b2b_done2", done, 1);
        chk("b2b_res2", result, eb[23:8]);
        chk("b2b_f2", f_out, eb[7:0]);

        // reset during HI aborts with no done pulse
        op = 2'd1; opa = 16'h1234; opb = 16'h4321; f_in = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rhi_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rhi_busy0", busy, 0);
        chk("rhi_done0", done, 0);
        chk("rhi_result", result, 16'h0000);
        chk("rhi_f_out", f_out, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rhi_no_done", done, 0);
        end

        // reset wins over start in the same cycle
        keep_r = result; keep_f = f_out;
        reset = 1'b1; start = 1'b1; op = 2'd0;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("rprio_busy", busy, 0);
        tick();
        chk("rprio_busy2", busy, 0);
        chk("rprio_res", result, keep_r);
        chk("rprio_f", f_out, keep_f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
